// File: rtl/random_word_packer_pkg.sv
// Shared definitions for the random word packer.
//   BYTE_W       : width of one upstream byte
//   pack_state_t : input handshake FSM encoding (legacy 1-bit encoding kept)
//   fill_width() : width of an occupancy counter able to hold 0..depth
package random_word_packer_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } pack_state_t;

  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/random_word_packer_word_fifo.sv
// word_fifo: parameterized synchronous FIFO, asynchronous active-high reset.
// Ports:
//   clk, rst       : clock (rising edge), async reset
//   push/push_data : write request and data; ignored when full unless a pop
//                    happens in the same cycle
//   pop            : read request; ignored when empty
//   head           : combinational view of the oldest entry
//   count          : occupancy 0..DEPTH
//   full           : count == DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module word_fifo
  import random_word_packer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = fill_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full = (count == CW'(DEPTH));
  assign head = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/random_word_packer.sv
// random_word_packer: takes bytes from the sponge byte generator over a
// 4-phase valid/received handshake, packs WORD_BYTES of them MSB-first
// (first byte ends in the top byte) and queues finished words in a FIFO
// presented as a ready/valid stream.
// Ports:
//   clk, rst     : clock (rising edge), async active-high reset
//   in_data      : upstream byte
//   in_valid     : upstream 4-phase request
//   in_received  : 4-phase acknowledge (registered)
//   out_word     : FIFO head word
//   out_valid    : FIFO non-empty
//   out_ready    : downstream takes the head this cycle
//   fill         : FIFO occupancy
//   health_fail  : sticky repetition-count failure flag
// Optional build macro RANDOM_WORD_PACKER_HEALTH_EN enables the
// repetition-count health test; without it health_fail is tied 0.
module random_word_packer
  import random_word_packer_pkg::*;
#(
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REPEAT_LIMIT = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BYTE_W-1:0]                  in_data,
  input  logic                               in_valid,
  output logic                               in_received,
  output logic [BYTE_W*WORD_BYTES-1:0]       out_word,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [fill_width(FIFO_DEPTH)-1:0]  fill,
  output logic                               health_fail
);

  localparam int unsigned WW  = BYTE_W * WORD_BYTES;
  localparam int unsigned BCW = $clog2(WORD_BYTES + 1);

  pack_state_t     state;
  logic [WW-1:0]   shift_reg;
  logic [BCW-1:0]  byte_cnt;
  logic            word_done;
  logic            capture;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            trip;

  // A completed word waiting for FIFO space blocks further captures.
  always_comb begin
    word_done = (byte_cnt == BCW'(WORD_BYTES));
    capture   = (state == ST_IDLE) && in_valid && !word_done;
    pop       = out_valid && out_ready;
    push      = word_done && (!fifo_full || pop) && !health_fail;
  end

`ifdef RANDOM_WORD_PACKER_HEALTH_EN
  localparam int unsigned RCW = $clog2(REPEAT_LIMIT + 1);

  logic [RCW-1:0]    run_cnt;
  logic [RCW-1:0]    run_next;
  logic [BYTE_W-1:0] prev_byte;

  // run_cnt == 0 means no byte seen yet since reset.
  always_comb begin
    run_next = ((run_cnt != '0) && (in_data == prev_byte)) ? run_cnt + 1'b1 : RCW'(1);
    trip     = capture && !health_fail && (run_next == RCW'(REPEAT_LIMIT));
  end

  // Updates stop once tripped, so run_cnt never exceeds REPEAT_LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt     <= '0;
      prev_byte   <= '0;
      health_fail <= 1'b0;
    end else if (capture && !health_fail) begin
      run_cnt   <= run_next;
      prev_byte <= in_data;
      if (trip) health_fail <= 1'b1;
    end
  end
`else
  assign trip        = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (capture)   state <= ST_ACK;
        ST_ACK:  if (!in_valid) state <= ST_IDLE;
        default:                state <= ST_IDLE;
      endcase
      // push needs a full word and capture needs a partial one, so they
      // never coincide; after a health trip bytes are acked but dropped.
      if (push || trip) begin
        byte_cnt <= '0;
      end else if (capture && !health_fail) begin
        shift_reg <= {shift_reg[WW-BYTE_W-1:0], in_data};
        byte_cnt  <= byte_cnt + 1'b1;
      end
    end
  end

  assign in_received = (state == ST_ACK);

  word_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_reg),
    .pop       (pop),
    .head      (out_word),
    .count     (fill),
    .full      (fifo_full)
  );

  assign out_valid = (fill != '0);

endmodule

// File: tb/tb_random_word_packer.sv
// Self-checking bench for random_word_packer (WORD_BYTES=4, FIFO_DEPTH=4).
// Words expected from the driven bytes are queued as bytes are acked and
// compared when the DUT hands a word downstream.
module tb_random_word_packer;

  localparam int unsigned WB    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_received;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fill;
  logic        health_fail;

  always #5 clk = ~clk;

  random_word_packer #(
    .WORD_BYTES   (WB),
    .FIFO_DEPTH   (DEPTH),
    .REPEAT_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_received (in_received),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fill        (fill),
    .health_fail (health_fail)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] acc;
  int unsigned acc_n;
  logic [7:0]  m_prev;
  int unsigned m_run;
  bit          m_hf;

  int unsigned valid_cycles = 0;
  int unsigned pops = 0;
  logic [31:0] last_word = '0;

  bit          ak;
  bit          done;
  logic [7:0]  b;
  logic [7:0]  lastb;
  int unsigned v0;
  int unsigned p0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    acc_n  = 0;
    acc    = '0;
    m_run  = 0;
    m_prev = '0;
    m_hf   = 1'b0;
    exp_q.delete();
  endtask

  // Reference behaviour for one acked byte.
  task automatic model_byte(input logic [7:0] d);
`ifdef RANDOM_WORD_PACKER_HEALTH_EN
    if (m_hf) return;
    m_run  = (m_run != 0 && d == m_prev) ? m_run + 1 : 1;
    m_prev = d;
    if (m_run == LIMIT) begin
      m_hf  = 1'b1;
      acc_n = 0;
      return;
    end
`endif
    acc = {acc[23:0], d};
    acc_n++;
    if (acc_n == WB) begin
      exp_q.push_back(acc);
      acc_n = 0;
    end
  endtask

  // 4-phase transfer. If no ack arrives within tmo cycles, in_valid is left
  // high and acked=0.
  task automatic send_byte(input logic [7:0] d, input int tmo, output bit acked);
    in_data  = d;
    in_valid = 1'b1;
    acked    = 1'b0;
    for (int i = 0; i < tmo; i++) begin
      @(negedge clk);
      if (in_received) begin
        acked = 1'b1;
        break;
      end
    end
    if (!acked) return;
    model_byte(d);
    in_valid = 1'b0;
    for (int i = 0; i < tmo; i++) begin
      @(negedge clk);
      if (!in_received) return;
    end
    check_eq("ack_release_timeout", in_received, 0);
  endtask

  task automatic send_word(input logic [31:0] w, input string tag);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], 20, ak);
      check_eq(tag, ak, 1);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic wait_drain(input int tmo, input string tag);
    for (int i = 0; i < tmo; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fill == 0) break;
    end
    check_eq({tag, "_fill"}, fill, 0);
    check_eq({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Output monitor: one handed-over word per out_valid & out_ready cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        pops++;
        last_word = out_word;
        check_eq("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_eq("word", out_word, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_in_received", in_received, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_word", out_word, 0);
    check_eq("rst_fill", fill, 0);
    check_eq("rst_health", health_fail, 0);
    rst = 1'b0;

    // Ordering: first byte lands in the MSB.
    set_ready(1'b1);
    @(negedge clk);
    v0 = valid_cycles;
    send_word(32'h7c700ee6, "order_ack");
    wait_drain(20, "order");
    check_eq("order_word", last_word, 32'h7c700ee6);
    check_eq("order_valid_cycles", valid_cycles - v0, 1);

    // Back-pressure: 4 words fill the FIFO, the 5th waits, 21st byte blocked.
    p0 = pops;
    set_ready(1'b0);
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(8'h10 + i), 20, ak);
      check_eq("bp_ack", ak, 1);
      if (i == 15) begin
        repeat (3) @(negedge clk);
        check_eq("bp_fill_16", fill, 4);
      end
    end
    repeat (3) @(negedge clk);
    check_eq("bp_fill_20", fill, 4);
    send_byte(8'h24, 20, ak);
    check_eq("bp_21_blocked", ak, 0);
    check_eq("bp_21_no_ack", in_received, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq("bp_fill_after_pop", fill, 4);
    check_eq("bp_first_word", last_word, 32'h10111213);
    send_byte(8'h24, 20, ak);
    check_eq("bp_21_acked", ak, 1);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'h25 + i), 20, ak);
      check_eq("bp_tail_ack", ak, 1);
    end
    set_ready(1'b1);
    wait_drain(100, "bp");
    check_eq("bp_pops", pops - p0, 6);
    check_eq("bp_last_word", last_word, 32'h24252627);

    // Wrap-around: 12 words while out_ready toggles every cycle.
    p0    = pops;
    lastb = 8'h27;
    done  = 1'b0;
    set_ready(1'b0);
    fork
      begin
        for (int k = 0; k < 3000 && !done; k++) begin
          @(posedge clk);
          #1 out_ready = ~out_ready;
        end
      end
      begin
        for (int w = 0; w < 12 * 4; w++) begin
          b = 8'($urandom);
          if (b == lastb) b = b ^ 8'h01;
          lastb = b;
          send_byte(b, 20, ak);
          check_eq("wrap_ack", ak, 1);
        end
        done = 1'b1;
      end
    join
    set_ready(1'b1);
    wait_drain(200, "wrap");
    check_eq("wrap_pops", pops - p0, 12);

    // Handshake hold: in_valid high for 10 cycles captures exactly one byte.
    in_data  = 8'ha5;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_received) break;
    end
    check_eq("hold_ack_seen", in_received, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("hold_ack_high", in_received, 1);
    end
    model_byte(8'ha5);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("hold_release", in_received, 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'hb6 + 8'h11 * i), 20, ak);
      check_eq("hold_tail_ack", ak, 1);
    end
    wait_drain(20, "hold");
    check_eq("hold_word", last_word, 32'ha5b6c7d8);

    // Reset mid-handshake with a word queued and a partial word in progress.
    set_ready(1'b0);
    send_word(32'h01020304, "rstm_ack");
    send_byte(8'h11, 20, ak);
    send_byte(8'h22, 20, ak);
    in_data  = 8'h33;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_received) break;
    end
    check_eq("rstm_in_ack", in_received, 1);
    check_eq("rstm_pre_fill", fill, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rstm_in_received", in_received, 0);
    check_eq("rstm_out_valid", out_valid, 0);
    check_eq("rstm_fill", fill, 0);
    check_eq("rstm_out_word", out_word, 0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_ready(1'b1);
    send_word(32'h087b2de2, "post_rst_ack");
    wait_drain(20, "post_rst");
    check_eq("post_rst_word", last_word, 32'h087b2de2);

    // Health: four identical bytes.
    v0 = valid_cycles;
    send_word(32'h55555555, "health_ack");
    repeat (4) @(negedge clk);
`ifdef RANDOM_WORD_PACKER_HEALTH_EN
    check_eq("health_flag", health_fail, 1);
    check_eq("health_fill", fill, 0);
    send_word(32'h01020304, "health_drop_ack");
    repeat (4) @(negedge clk);
    check_eq("health_fill_after", fill, 0);
    check_eq("health_no_valid", valid_cycles - v0, 0);
    check_eq("health_flag_sticky", health_fail, 1);
`else
    check_eq("health_flag_off", health_fail, 0);
    wait_drain(20, "health_off");
    check_eq("health_off_word", last_word, 32'h55555555);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
